// File: rtl/pir_input_conditioner.sv
// Synchronises, warm-up-gates and debounces three raw PIR pins; emits rate-limited motion events.
// Optional event counter with count_clear enabled by defining PIR_EVENT_COUNT_EN.
module pir_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned WARMUP_CYCLES   = 1000,
   parameter int unsigned HOLDOFF_CYCLES  = 50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pir_raw_1,
   input  logic       pir_raw_2,
   input  logic       pir_raw_3,
   output logic       pir_sensor_1,
   output logic       pir_sensor_2,
   output logic       pir_sensor_3,
   output logic       sensors_ready,
   output logic       motion_event,
   output logic [2:0] motion_mask
`ifdef PIR_EVENT_COUNT_EN
   ,
   input  logic        count_clear,
   output logic [15:0] event_count
`endif
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int unsigned WW = $clog2(WARMUP_CYCLES) + 1;
   localparam int unsigned HW = $clog2(HOLDOFF_CYCLES) + 1;

   localparam logic [DW-1:0] DebLast  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WW-1:0] WarmLast = WW'(WARMUP_CYCLES - 1);
   localparam logic [HW-1:0] HoldLoad = HW'(HOLDOFF_CYCLES);

   typedef enum logic {StWarmup, StArmed} state_e;

   state_e               state_q, state_d;
   logic [WW-1:0]        warm_q, warm_d;
   logic                 ready_q, ready_d;
   logic [2:0]           sync1_q, sync_q;
   logic [2:0]           clean_q, clean_d;
   logic [2:0][DW-1:0]   deb_q, deb_d;
   logic [HW-1:0]        hold_q, hold_d;
   logic                 event_q, event_d;
   logic [2:0]           mask_q, mask_d;
   logic [2:0]           rise;
   logic [2:0]           raw;

   assign raw = {pir_raw_3, pir_raw_2, pir_raw_1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync_q  <= '0;
      end else begin
         sync1_q <= raw;
         sync_q  <= sync1_q;
      end
   end

   // Warm-up sequencing and per-channel debounce
   always_comb begin
      state_d = state_q;
      warm_d  = warm_q;
      ready_d = ready_q;
      clean_d = clean_q;
      deb_d   = deb_q;
      case (state_q)
         StWarmup: begin
            clean_d = '0;
            deb_d   = '0;
            if (warm_q == WarmLast) begin
               state_d = StArmed;
               warm_d  = '0;
               ready_d = 1'b1;
            end else begin
               warm_d = warm_q + WW'(1);
            end
         end
         StArmed: begin
            for (int i = 0; i < 3; i++) begin
               if (sync_q[i] == clean_q[i]) begin
                  deb_d[i] = '0;
               end else if (deb_q[i] == DebLast) begin
                  clean_d[i] = sync_q[i];
                  deb_d[i]   = '0;
               end else begin
                  deb_d[i] = deb_q[i] + DW'(1);
               end
            end
         end
         default: state_d = StWarmup;
      endcase
   end

   assign rise = clean_d & ~clean_q;

   // Rises while hold-off is running are dropped without reloading it
   always_comb begin
      event_d = 1'b0;
      mask_d  = '0;
      hold_d  = hold_q;
      if ((|rise) && (hold_q == '0)) begin
         event_d = 1'b1;
         mask_d  = rise;
         hold_d  = HoldLoad;
      end else if (hold_q != '0) begin
         hold_d = hold_q - HW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StWarmup;
         warm_q  <= '0;
         ready_q <= 1'b0;
         clean_q <= '0;
         deb_q   <= '0;
         hold_q  <= '0;
         event_q <= 1'b0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         warm_q  <= warm_d;
         ready_q <= ready_d;
         clean_q <= clean_d;
         deb_q   <= deb_d;
         hold_q  <= hold_d;
         event_q <= event_d;
         mask_q  <= mask_d;
      end
   end

   assign pir_sensor_1  = clean_q[0];
   assign pir_sensor_2  = clean_q[1];
   assign pir_sensor_3  = clean_q[2];
   assign sensors_ready = ready_q;
   assign motion_event  = event_q;
   assign motion_mask   = mask_q;

`ifdef PIR_EVENT_COUNT_EN
   logic [15:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (count_clear) begin
         count_q <= '0;
      end else if (event_q && (count_q != 16'hFFFF)) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign event_count = count_q;
`endif

endmodule

// File: tb/tb_pir_input_conditioner.sv
// Bench for pir_input_conditioner: debounce vector table, scoreboarded events, corner sequences.
module tb_pir_input_conditioner;

   localparam int unsigned W = 8;
   localparam int unsigned D = 4;
   localparam int unsigned H = 10;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [2:0] raw = '0;
   logic       pir_sensor_1, pir_sensor_2, pir_sensor_3;
   logic       sensors_ready, motion_event;
   logic [2:0] motion_mask;
   logic [2:0] sens;
`ifdef PIR_EVENT_COUNT_EN
   logic        count_clear = 1'b0;
   logic [15:0] event_count;
   int          count_model = 0;
`endif

   assign sens = {pir_sensor_3, pir_sensor_2, pir_sensor_1};

   pir_input_conditioner #(
      .DEBOUNCE_CYCLES(D),
      .WARMUP_CYCLES  (W),
      .HOLDOFF_CYCLES (H)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pir_raw_1    (raw[0]),
      .pir_raw_2    (raw[1]),
      .pir_raw_3    (raw[2]),
      .pir_sensor_1 (pir_sensor_1),
      .pir_sensor_2 (pir_sensor_2),
      .pir_sensor_3 (pir_sensor_3),
      .sensors_ready(sensors_ready),
      .motion_event (motion_event),
      .motion_mask  (motion_mask)
`ifdef PIR_EVENT_COUNT_EN
      ,
      .count_clear  (count_clear),
      .event_count  (event_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; logic [2:0] mask;} exp_t;
   typedef struct {int ch; int width; bit rises;} vec_t;

   exp_t sb[$];
   vec_t vecs[6];
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // One clock; outputs sampled 1 time unit after the edge and matched to the scoreboard
   task automatic tick();
      exp_t e;
`ifdef PIR_EVENT_COUNT_EN
      logic pre_ev, pre_clr;
      pre_ev  = motion_event;
      pre_clr = count_clear;
`endif
      @(posedge clk);
      #1;
      cyc++;
      if (motion_event) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL event_unexpected at cycle %0d: mask %b, expected no event", cyc,
                     motion_mask);
         end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || e.mask !== motion_mask) begin
               errors++;
               $display("FAIL event_match: got cycle %0d mask %b expected cycle %0d mask %b",
                        cyc, motion_mask, e.cyc, e.mask);
            end
         end
      end else begin
         check("mask_idle", 32'(motion_mask), 32'h0);
         if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL event_missed: no event by cycle %0d, expected cycle %0d mask %b",
                     cyc, e.cyc, e.mask);
         end
      end
`ifdef PIR_EVENT_COUNT_EN
      if (!rst_n || pre_clr) count_model = 0;
      else if (pre_ev && count_model != 32'hFFFF) count_model++;
      check("event_count", 32'(event_count), 32'(count_model));
`endif
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic check_all_zero(input string name);
      check(name, {28'h0, sens, sensors_ready}, 32'h0);
      check({name, "_event"}, {28'h0, motion_mask, motion_event}, 32'h0);
   endtask

   initial begin
      int k0, e0;
      vecs[0] = '{ch: 1, width: 3, rises: 1'b0};
      vecs[1] = '{ch: 1, width: 6, rises: 1'b1};
      vecs[2] = '{ch: 0, width: 4, rises: 1'b1};
      vecs[3] = '{ch: 2, width: 2, rises: 1'b0};
      vecs[4] = '{ch: 2, width: 5, rises: 1'b1};
      vecs[5] = '{ch: 0, width: 1, rises: 1'b0};

      // Power-on reset; sensor 1 already high when reset releases
      #2 rst_n = 1'b0;
      #1 check_all_zero("reset_outputs");
`ifdef PIR_EVENT_COUNT_EN
      count_model = 0;
`endif
      repeat (3) tick();
      rst_n  = 1'b1;
      raw[0] = 1'b1;
      cyc    = 0;
      sb.push_back('{cyc: 12, mask: 3'b001});
      for (int i = 1; i <= 12; i++) begin
         tick();
         check("warmup_ready", 32'(sensors_ready), 32'(cyc >= int'(W)));
         check("warmup_sensor", 32'(sens), (cyc >= 12) ? 32'h1 : 32'h0);
      end
      raw[0] = 1'b0;
      wait_until(30);
      check("quiet_after_warmup", 32'(sens), 32'h0);

      // Debounce vectors: one raw pulse per record from a quiet, armed state
      foreach (vecs[v]) begin
         k0 = cyc;
         raw[vecs[v].ch] = 1'b1;
         if (vecs[v].rises) sb.push_back('{cyc: k0 + 2 + int'(D), mask: 3'(1 << vecs[v].ch)});
         for (int n = 1; n <= vecs[v].width + int'(D) + 4; n++) begin
            tick();
            if (cyc == k0 + vecs[v].width) raw[vecs[v].ch] = 1'b0;
            if (cyc == k0 + 1 + int'(D))
               check("deb_before", 32'(sens[vecs[v].ch]), 32'h0);
            if (cyc == k0 + 2 + int'(D))
               check("deb_level", 32'(sens[vecs[v].ch]), 32'(vecs[v].rises));
         end
         wait_until(k0 + vecs[v].width + int'(D) + int'(H) + 5);
         check("deb_settled", 32'(sens), 32'h0);
      end

      // Simultaneous rises on sensors 1 and 3
      k0  = cyc;
      raw = 3'b101;
      sb.push_back('{cyc: k0 + 6, mask: 3'b101});
      repeat (6) tick();
      check("simul_level", 32'(sens), 32'h5);
      raw = 3'b000;
      wait_until(k0 + 14 + int'(H));
      check("simul_settled", 32'(sens), 32'h0);

      // Hold-off: sensor 2 rise suppressed, sensor 3 rise after expiry accepted
      k0     = cyc;
      e0     = k0 + 6;
      raw[0] = 1'b1;
      sb.push_back('{cyc: e0, mask: 3'b001});
      sb.push_back('{cyc: e0 + 11, mask: 3'b100});
      while (cyc < e0 + 13) begin
         tick();
         if (cyc == k0 + 5) raw[1] = 1'b1;
         if (cyc == k0 + 11) raw[2] = 1'b1;
         if (cyc == e0 + 5) begin
            check("holdoff_s2_level", 32'(sens), 32'h3);
            check("holdoff_s2_no_event", 32'(motion_event), 32'h0);
         end
         if (cyc == e0 + 11) check("holdoff_s3_level", 32'(sens), 32'h7);
      end

      // Asynchronous reset mid-operation, away from any clock edge
      #2 rst_n = 1'b0;
      #1 check_all_zero("midop_reset");
      repeat (3) tick();
      rst_n = 1'b1;
      cyc   = 0;
      sb.push_back('{cyc: 12, mask: 3'b111});
      for (int i = 1; i <= 12; i++) begin
         tick();
`ifdef PIR_EVENT_COUNT_EN
         // Clear coincides with the motion_event cycle
         count_clear = (cyc == 12);
`endif
         check("rewarm_ready", 32'(sensors_ready), 32'(cyc >= int'(W)));
         check("rewarm_sensor", 32'(sens), (cyc >= 12) ? 32'h7 : 32'h0);
      end
      tick();
`ifdef PIR_EVENT_COUNT_EN
      count_clear = 1'b0;
      check("count_cleared", 32'(event_count), 32'h0);
`endif
      raw = 3'b000;
      repeat (15) tick();
      check("scoreboard_drained", 32'(sb.size()), 32'h0);
      check("final_quiet", 32'(sens), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
